// File: rtl/exe_sequencer.sv
// Execute-stage controller: accepts one decoded instruction at a time, steers it to
// the ALU, branch or data-move unit, sequences loads and counts retirements.
module exe_sequencer #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_WAIT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [1:0]            issue_class,
  input  logic [2:0]            issue_opcode,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [31:0]           alu_y,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  input  logic [31:0]           mem_rdata,
  output logic                  alu_en,
  output logic                  br_en,
  output logic                  dm_en,
  output logic [2:0]            unit_opcode,
  output logic                  mem_we,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  pc_load,
  output logic [31:0]           pc_target,
  output logic                  illegal,
  output logic                  busy,
  output logic [31:0]           retire_cnt
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_BR  = 2'b01;
  localparam logic [1:0] CLS_DM  = 2'b10;

  localparam logic [2:0] OP_STORE  = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_BR_BAD = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXEC     = 2'b01,
    MEM_WAIT = 2'b10,
    WB       = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cls_q;
  logic [2:0]              op_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    illegal_q;
  logic [31:0]             retire_q;

  logic                    transfer;
  logic                    legal;
  logic                    retire;
  logic                    rd_nonzero;

  assign issue_ready = (state_q == IDLE) && !reset;
  assign transfer    = issue_valid && issue_ready;
  assign rd_nonzero  = (rd_q != '0);

  // Legality of the instruction currently offered by the decoder
  always_comb begin
    legal = 1'b0;
    case (issue_class)
      CLS_ALU: legal = 1'b1;
      CLS_BR:  legal = (issue_opcode != OP_BR_BAD);
      CLS_DM:  legal = (issue_opcode == OP_STORE) || (issue_opcode == OP_LOAD);
      default: legal = 1'b0;
    endcase
  end

  // Next-state and unit-control decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_en   = 1'b0;
    br_en    = 1'b0;
    dm_en    = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = '0;
    pc_load  = 1'b0;
    retire   = 1'b0;

    case (state_q)
      IDLE: begin
        if (transfer && legal) state_d = EXEC;
      end

      EXEC: begin
        state_d = IDLE;
        case (cls_q)
          CLS_ALU: begin
            alu_en   = 1'b1;
            rf_we    = rd_nonzero;
            rf_wdata = alu_y;
            retire   = 1'b1;
          end
          CLS_BR: begin
            br_en   = 1'b1;
            pc_load = br_taken;
            retire  = 1'b1;
          end
          CLS_DM: begin
            dm_en = 1'b1;
            if (op_q == OP_LOAD) begin
              cnt_d   = CNT_W'(LOAD_WAIT);
              state_d = MEM_WAIT;
            end else begin
              mem_we = 1'b1;
              retire = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      MEM_WAIT: begin
        dm_en = 1'b1;
        cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        if (cnt_q == CNT_W'(1)) state_d = WB;
      end

      WB: begin
        dm_en    = 1'b1;
        rf_we    = rd_nonzero;
        rf_wdata = mem_rdata;
        retire   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, latched instruction fields, load wait counter and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cls_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= transfer && !legal;
      if (transfer) begin
        cls_q <= issue_class;
        op_q  <= issue_opcode;
        rd_q  <= issue_rd;
      end
      if (retire) retire_q <= retire_q + 32'd1;
    end
  end

  assign unit_opcode = op_q;
  assign rf_waddr    = rd_q;
  assign pc_target   = br_target;
  assign illegal     = illegal_q;
  assign busy        = (state_q != IDLE);
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_exe_sequencer.sv
// Scoreboard bench for exe_sequencer: stimulus pushes expected per-cycle unit
// activity, a negedge monitor pops and compares whenever any strobe is active.
module tb_exe_sequencer;

  localparam int unsigned RW = 5;
  localparam int unsigned LW = 4;

  typedef struct packed {
    logic          alu_en;
    logic          br_en;
    logic          dm_en;
    logic          mem_we;
    logic          rf_we;
    logic [RW-1:0] waddr;
    logic [31:0]   wdata;
    logic          pc_load;
    logic [31:0]   target;
    logic          illegal;
    logic [2:0]    op;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic          issue_ready;
  logic [1:0]    issue_class;
  logic [2:0]    issue_opcode;
  logic [RW-1:0] issue_rd;
  logic [31:0]   alu_y;
  logic          br_taken;
  logic [31:0]   br_target;
  logic [31:0]   mem_rdata;
  logic          alu_en, br_en, dm_en, mem_we, rf_we, pc_load, illegal, busy;
  logic [2:0]    unit_opcode;
  logic [RW-1:0] rf_waddr;
  logic [31:0]   rf_wdata, pc_target, retire_cnt;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  logic [31:0] exp_retire;

  exe_sequencer #(.REG_ADDR_W(RW), .LOAD_WAIT(LW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_class(issue_class), .issue_opcode(issue_opcode), .issue_rd(issue_rd),
    .alu_y(alu_y), .br_taken(br_taken), .br_target(br_target), .mem_rdata(mem_rdata),
    .alu_en(alu_en), .br_en(br_en), .dm_en(dm_en), .unit_opcode(unit_opcode),
    .mem_we(mem_we), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_load(pc_load), .pc_target(pc_target), .illegal(illegal), .busy(busy),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o         = '0;
    o.alu_en  = alu_en;
    o.br_en   = br_en;
    o.dm_en   = dm_en;
    o.mem_we  = mem_we;
    o.rf_we   = rf_we;
    o.pc_load = pc_load;
    o.illegal = illegal;
    if (rf_we) begin
      o.waddr = rf_waddr;
      o.wdata = rf_wdata;
    end
    if (pc_load) o.target = pc_target;
    if (alu_en || br_en || dm_en) o.op = unit_opcode;
    return o;
  endfunction

  // Monitor: every cycle with visible activity must match the next expected entry
  always @(negedge clk) begin
    obs_t o, e;
    if (!reset && (alu_en || br_en || dm_en || mem_we || rf_we || pc_load || illegal)) begin
      o = sample();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_activity got=%h want=none", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL activity got=%h want=%h", o, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic obs_t illegal_ev();
    obs_t e;
    e         = '0;
    e.illegal = 1'b1;
    return e;
  endfunction

  // Expected per-cycle activity for one instruction, from the current operand inputs
  task automatic push_expected(input logic [1:0] c, input logic [2:0] op, input logic [RW-1:0] rd);
    obs_t e;
    e    = '0;
    e.op = op;
    case (c)
      2'b00: begin
        e.alu_en = 1'b1;
        e.rf_we  = (rd != '0);
        if (e.rf_we) begin e.waddr = rd; e.wdata = alu_y; end
        exp_q.push_back(e);
        exp_retire = exp_retire + 32'd1;
      end
      2'b01: begin
        if (op == 3'd7) exp_q.push_back(illegal_ev());
        else begin
          e.br_en   = 1'b1;
          e.pc_load = br_taken;
          if (br_taken) e.target = br_target;
          exp_q.push_back(e);
          exp_retire = exp_retire + 32'd1;
        end
      end
      2'b10: begin
        e.dm_en = 1'b1;
        if (op == 3'b000) begin
          e.mem_we = 1'b1;
          exp_q.push_back(e);
          exp_retire = exp_retire + 32'd1;
        end else if (op == 3'b011) begin
          for (int i = 0; i < int'(LW) + 1; i++) exp_q.push_back(e);
          e.rf_we = (rd != '0);
          if (e.rf_we) begin e.waddr = rd; e.wdata = mem_rdata; end
          exp_q.push_back(e);
          exp_retire = exp_retire + 32'd1;
        end else exp_q.push_back(illegal_ev());
      end
      default: exp_q.push_back(illegal_ev());
    endcase
  endtask

  // Present an instruction and hold it until the handshake completes
  task automatic issue(input logic [1:0] c, input logic [2:0] op, input logic [RW-1:0] rd);
    int n;
    n = 0;
    @(negedge clk); #1;
    issue_valid  = 1'b1;
    issue_class  = c;
    issue_opcode = op;
    issue_rd     = rd;
    push_expected(c, op, rd);
    while (!issue_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got=ready_low want=ready_high");
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      check("ready_low_while_busy", 32'(issue_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout got=busy want=idle");
    end
  endtask

  initial begin
    reset        = 1'b1;
    issue_valid  = 1'b0;
    issue_class  = '0;
    issue_opcode = '0;
    issue_rd     = '0;
    alu_y        = '0;
    br_taken     = 1'b0;
    br_target    = '0;
    mem_rdata    = '0;
    exp_retire   = '0;

    repeat (3) @(negedge clk);
    check("ready_in_reset", 32'(issue_ready), 32'd0);
    check("busy_in_reset", 32'(busy), 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("retire_after_reset", retire_cnt, 32'd0);
    check("ready_after_reset", 32'(issue_ready), 32'd1);

    // ALU write-back
    alu_y = 32'h0000_0007;
    issue(2'b00, 3'b000, 5'd3);
    wait_done();
    check("retire_alu", retire_cnt, exp_retire);
    check("ready_after_alu", 32'(issue_ready), 32'd1);

    // Load through MEM_WAIT into WB
    mem_rdata = 32'hDEAD_BEEF;
    issue(2'b10, 3'b011, 5'd5);
    wait_done();
    check("retire_load", retire_cnt, exp_retire);

    // Branch taken then not taken
    br_taken  = 1'b1;
    br_target = 32'h0000_0040;
    issue(2'b01, 3'd1, 5'd0);
    wait_done();
    br_taken = 1'b0;
    issue(2'b01, 3'd1, 5'd0);
    wait_done();
    check("retire_branch", retire_cnt, exp_retire);

    // Illegal encodings leave the count alone
    issue(2'b11, 3'd2, 5'd7);
    wait_done();
    issue(2'b10, 3'b110, 5'd4);
    wait_done();
    issue(2'b01, 3'd7, 5'd1);
    wait_done();
    @(negedge clk);
    check("retire_illegal", retire_cnt, exp_retire);

    // rd==0 suppression, store, and an ALU to the top register
    alu_y = 32'h0000_1234;
    issue(2'b00, 3'd5, 5'd0);
    wait_done();
    issue(2'b10, 3'b000, 5'd9);
    wait_done();
    alu_y = 32'hAAAA_5555;
    issue(2'b00, 3'd7, 5'd31);
    wait_done();
    check("retire_misc", retire_cnt, exp_retire);

    // Reset during MEM_WAIT aborts the load: only EXEC and two wait cycles are seen
    mem_rdata = 32'h0000_0011;
    issue(2'b10, 3'b011, 5'd6);
    repeat (int'(LW) - 1) void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    exp_retire = '0;
    @(negedge clk);
    check("abort_ready_in_reset", 32'(issue_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_strobes", {29'd0, rf_we, dm_en, mem_we}, 32'd0);
    #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_retire", retire_cnt, exp_retire);
    check("abort_no_pending", 32'(exp_q.size()), 32'd0);

    // Counter wrap from all-ones
    #1 force dut.retire_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retire_q;
    exp_retire = 32'hFFFF_FFFF;
    check("retire_preload", retire_cnt, exp_retire);
    alu_y = 32'h0000_0001;
    issue(2'b00, 3'd2, 5'd8);
    wait_done();
    check("retire_wrap", retire_cnt, exp_retire);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_sequencer.md
Name: exe_sequencer

Overview:
- Execute-stage controller. Accepts one decoded instruction at a time from the decoder over a valid/ready handshake.
- Steers the instruction to exactly one execution unit: ALU, branch, or data-move (load/store). Pulses that unit's enable and sequences multi-cycle loads.
- Produces the register-file write-back, the store strobe and the PC-load request, and counts retired instructions.
- Sits between the decode stage and the alu/branch/data_mov units.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_WAIT, 1, cycles between load address issue and valid mem_rdata. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decoder presents an instruction.
- issue_ready  out  1  sequencer accepts this cycle.
- issue_class  in  2  00 ALU, 01 branch, 10 data-move, 11 illegal.
- issue_opcode  in  3  unit opcode.
- issue_rd  in  REG_ADDR_W  destination register.
- alu_y  in  32  ALU result.
- br_taken  in  1  branch condition result.
- br_target  in  32  branch target address.
- mem_rdata  in  32  load data from memory.
- alu_en  out  1  ALU enable.
- br_en  out  1  branch unit enable.
- dm_en  out  1  data-move enable.
- unit_opcode  out  3  latched opcode, driven to all units.
- mem_we  out  1  store strobe.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  write-back register.
- rf_wdata  out  32  write-back data.
- pc_load  out  1  load PC with pc_target.
- pc_target  out  32  new PC.
- illegal  out  1  one-cycle pulse: instruction rejected.
- busy  out  1  state != IDLE.
- retire_cnt  out  32  retired-instruction count.

Behaviour:
- Reset:
  - state = IDLE; latched class/opcode/rd = 0; wait counter = 0; retire_cnt = 0.
  - All strobes (alu_en, br_en, dm_en, mem_we, rf_we, pc_load, illegal) = 0; busy = 0.
  - issue_ready = 0 while reset is high.
  - Reset mid-operation aborts the instruction: no write-back, store or pc_load follows, and it is not counted.
- Handshake:
  - issue_ready = 1 only in IDLE and not in reset.
  - Transfer occurs when issue_valid && issue_ready; class/opcode/rd are latched on that edge.
  - The decoder holds its inputs until transfer.
- Legal instructions:
  - Class 00 with any opcode.
  - Class 01 with opcode 0..6.
  - Class 10 with opcode 000 (store) or 011 (load).
- Illegal instructions (class 11, class 01 with opcode 7, any other class-10 opcode):
  - Accepted, then illegal = 1 for the following cycle.
  - State stays IDLE; no enable is raised; retire_cnt is not incremented.
- States: IDLE, EXEC, MEM_WAIT, WB.
  - IDLE -> EXEC when a legal instruction transfers.
  - EXEC lasts one cycle. Exactly one unit enable is high, and unit_opcode = latched opcode.
    - ALU: rf_we = 1, rf_wdata = alu_y (combinational pass-through), rf_waddr = rd; then -> IDLE.
    - Branch: pc_load = br_taken, pc_target = br_target; then -> IDLE.
    - Store: mem_we = 1; then -> IDLE.
    - Load: wait counter loaded with LOAD_WAIT; then -> MEM_WAIT.
  - MEM_WAIT: dm_en stays high; the counter decrements each cycle; -> WB on the cycle the counter reaches 1.
  - WB: dm_en = 1, rf_we = 1, rf_wdata = mem_rdata, rf_waddr = rd; then -> IDLE.
- Register 0 is never written: rf_we is forced to 0 when rd == 0. The instruction still retires.
- retire_cnt increments by 1 on the final cycle of every legal instruction. Those final cycles are EXEC for ALU, branch and store, and WB for load. The count wraps 0xFFFFFFFF -> 0.
- Latency, with transfer at edge N:
  - ALU, branch and store complete in cycle N+1.
  - Load has MEM_WAIT in cycles N+2..N+1+LOAD_WAIT and WB in cycle N+2+LOAD_WAIT.
  - Next acceptance is possible in the cycle after completion.
- pc_target and rf_wdata are don't-care when their strobe is low. Every strobe is low in any state not listed above.

Test Plan:
- Reset, then ALU class 00, opcode 000, rd = 3, alu_y = 0x00000007 -> after 1 cycle: alu_en = 1, rf_we = 1, rf_waddr = 3, rf_wdata = 7; retire_cnt = 1; issue_ready returns to 1 the next cycle.
- Load class 10, opcode 011, rd = 5, LOAD_WAIT = 1, mem_rdata = 0xDEADBEEF -> dm_en high for 3 cycles; rf_we = 1 with 0xDEADBEEF in cycle N+3; issue_ready = 0 throughout.
- Branch class 01, opcode 1: br_taken = 1 with target 0x40 -> pc_load = 1, pc_target = 0x40; repeat with br_taken = 0 -> pc_load = 0; retire_cnt += 2 total.
- Illegal class 11, then class 10 opcode 110 -> illegal pulses 1 cycle each; no enables or strobes; retire_cnt unchanged.
- ALU with rd = 0 -> rf_we stays 0; retire_cnt still increments. Store class 10, opcode 000 -> mem_we = 1 for exactly 1 cycle.
- Reset asserted during MEM_WAIT with LOAD_WAIT = 4 -> next cycle IDLE, all strobes 0, no WB; retire_cnt = 0. Preload retire_cnt to 0xFFFFFFFF via 2^32-1 retirements (forced), then one more retirement -> retire_cnt = 0.
